// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states, bus width.
package control_unit_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // Zero-extend a 3-bit register index onto the 8-bit mux select.
    function automatic logic [7:0] reg_sel(input logic [2:0] idx);
        return {5'b00000, idx};
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; drives the register-file write enables.
module dec3to8 (
    input  logic       en_i,
    input  logic [2:0] idx_i,
    output logic [7:0] onehot_o
);

    // Set exactly one bit when enabled, none otherwise.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches a 9-bit instruction from DIN in T0 and
// sequences mv / mvi / add / sub (1xx is a NOP) over T1..T3 as a Moore FSM.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [7:0]        selectR,
    output logic              selectG,
    output logic              selectDin,
    output logic [7:0]        Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done
);

    state_t     state_q, state_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       rin_en;

    // Only DIN[15:7] carries the instruction; the rest of the bus is data.
    logic       unused_din;
    assign unused_din = ^DIN;

    assign opcode = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];

    // IR captures the instruction only when a new instruction starts.
    always_comb begin
        ir_d = ir_q;
        if (state_q == T0 && Run) begin
            ir_d = DIN[15:7];
        end
    end

    // State and IR registers; reset returns to idle with a cleared IR.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and Moore output decode from state and IR.
    always_comb begin
        state_d   = state_q;
        selectR   = '0;
        selectG   = 1'b0;
        selectDin = 1'b0;
        rin_en    = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        AddSub    = 1'b0;
        Done      = 1'b0;
        unique case (state_q)
            T0: begin
                state_d = Run ? T1 : T0;
            end
            T1: begin
                unique case (opcode)
                    OP_MV: begin
                        selectR = reg_sel(ry);
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        selectDin = 1'b1;
                        rin_en    = 1'b1;
                        Done      = 1'b1;
                        state_d   = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        selectR = reg_sel(rx);
                        Ain     = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        Done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                selectR = reg_sel(ry);
                Gin     = 1'b1;
                AddSub  = opcode[0];
                state_d = T3;
            end
            T3: begin
                selectG = 1'b1;
                rin_en  = 1'b1;
                Done    = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

    // Every register write in this ISA targets Rx.
    dec3to8 u_rin_dec (
        .en_i     (rin_en),
        .idx_i    (rx),
        .onehot_o (Rin)
    );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-instruction expected-output schedule is
// compared every cycle, alongside literal checks of the documented vectors.
module tb_control_unit;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic [15:0] DIN;
    logic [7:0]  selectR;
    logic        selectG;
    logic        selectDin;
    logic [7:0]  Rin;
    logic        Ain;
    logic        Gin;
    logic        AddSub;
    logic        Done;

    int n_checks;
    int n_pass;
    bit finished;

    typedef struct packed {
        logic [7:0] selr;
        logic       selg;
        logic       seldin;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       done;
    } outs_t;

    outs_t sched[$];

    control_unit #(.DATA_W(16)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Run       (Run),
        .DIN       (DIN),
        .selectR   (selectR),
        .selectG   (selectG),
        .selectDin (selectDin),
        .Rin       (Rin),
        .Ain       (Ain),
        .Gin       (Gin),
        .AddSub    (AddSub),
        .Done      (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Model: when idle and Run is seen, lay out the whole instruction as a
    // list of per-cycle output sets; each later edge consumes one entry.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sched.delete();
        end else if (sched.size() != 0) begin
            void'(sched.pop_front());
        end else if (Run) begin
            int unsigned op, x, y;
            outs_t e;
            op = DIN[15:13];
            x  = DIN[12:10];
            y  = DIN[9:7];
            e = '0;
            case (op)
                0: begin
                    e.selr = 8'(y); e.rin = 8'(1 << x); e.done = 1'b1;
                    sched.push_back(e);
                end
                1: begin
                    e.seldin = 1'b1; e.rin = 8'(1 << x); e.done = 1'b1;
                    sched.push_back(e);
                end
                2, 3: begin
                    e.selr = 8'(x); e.ain = 1'b1;
                    sched.push_back(e);
                    e = '0;
                    e.selr = 8'(y); e.gin = 1'b1; e.addsub = (op == 3);
                    sched.push_back(e);
                    e = '0;
                    e.selg = 1'b1; e.rin = 8'(1 << x); e.done = 1'b1;
                    sched.push_back(e);
                end
                default: begin
                    e.done = 1'b1;
                    sched.push_back(e);
                end
            endcase
        end
    end

    // Compare DUT outputs to the schedule and the bus/enable invariants.
    always @(negedge Clock) begin
        if (!finished) begin
            outs_t exp_o, act_o;
            exp_o = (sched.size() != 0) ? sched[0] : '0;
            act_o = {selectR, selectG, selectDin, Rin, Ain, Gin, AddSub, Done};
            n_checks++;
            if (act_o === exp_o) n_pass++;
            else $display("FAIL model t=%0t actual=%h required=%h", $time, act_o, exp_o);
            n_checks++;
            if (!(selectG && selectDin) && (!(selectG || selectDin) || selectR == 8'd0)
                && $countones(Rin) <= 1)
                n_pass++;
            else
                $display("FAIL bus_invariant t=%0t actual selG=%b selDin=%b selR=%0d Rin=%b required exclusive/zero",
                         $time, selectG, selectDin, selectR, Rin);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    logic [7:0] done_mask;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        finished = 0;
        Reset    = 1'b1;
        Run      = 1'b0;
        DIN      = '0;
        repeat (2) cyc();
        chk("reset_outputs",
            {selectR, selectG, selectDin, Rin, Ain, Gin, AddSub, Done}, 32'h0);
        Reset = 1'b0;
        cyc();

        // mv R2,R5
        Run = 1'b1; DIN = 16'h0A80;
        cyc(); Run = 1'b0;
        chk("mv_selR", selectR, 5);
        chk("mv_Rin", Rin, 8'b00000100);
        chk("mv_Done", Done, 1);
        cyc();
        chk("mv_back_T0_Done", Done, 0);

        // mvi R3, immediate
        Run = 1'b1; DIN = 16'h2C00;
        cyc(); Run = 1'b0; DIN = 16'h1234;
        chk("mvi_selDin", selectDin, 1);
        chk("mvi_Rin", Rin, 8'b00001000);
        chk("mvi_Done", Done, 1);
        cyc();

        // add R1,R6
        Run = 1'b1; DIN = 16'h4700;
        cyc(); Run = 1'b0;
        chk("add_T1", {selectR, Ain, Done}, {8'd1, 1'b1, 1'b0});
        cyc();
        chk("add_T2", {selectR, Gin, AddSub, Rin}, {8'd6, 1'b1, 1'b0, 8'd0});
        cyc();
        chk("add_T3", {selectG, Rin, Done}, {1'b1, 8'b00000010, 1'b1});
        cyc();

        // sub R7,R0
        Run = 1'b1; DIN = 16'h7C00;
        cyc(); Run = 1'b0;
        cyc();
        chk("sub_T2", {selectR, Gin, AddSub}, {8'd0, 1'b1, 1'b1});
        cyc();
        chk("sub_T3", {Rin, Done}, {8'b10000000, 1'b1});
        cyc();

        // Run held: mv, NOP, add back-to-back; Done expected at cycles 2,4,8
        done_mask = '0;
        Run = 1'b1; DIN = 16'h0A80;
        done_mask[0] = Done;
        for (int k = 1; k < 8; k++) begin
            cyc();
            if (k == 1) DIN = 16'hC000;
            if (k == 3) DIN = 16'h4700;
            if (k == 7) Run = 1'b0;
            done_mask[k] = Done;
        end
        chk("stream_done_cycles", done_mask, 8'b10001010);
        cyc();

        // Reset in the middle of add (T2)
        Run = 1'b1; DIN = 16'h4700;
        cyc(); Run = 1'b0;
        cyc();
        chk("pre_reset_T2_Gin", Gin, 1);
        #1 Reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            {selectR, selectG, selectDin, Rin, Ain, Gin, AddSub, Done}, 32'h0);
        cyc();
        chk("reset_hold_outputs", {Gin, Rin, Done}, 32'h0);
        Reset = 1'b0;
        cyc();
        chk("post_reset_idle", {Gin, Rin, Done, Ain}, 32'h0);
        Run = 1'b1; DIN = 16'h0A80;
        cyc(); Run = 1'b0;
        chk("post_reset_first_mv", {selectR, Rin, Done}, {8'd5, 8'b00000100, 1'b1});
        cyc();

        // Sweep every opcode with distinct X/Y; checked by the model only
        for (int op = 0; op < 8; op++) begin
            logic [2:0] o3, x3, y3;
            o3 = 3'(op); x3 = 3'(op + 3); y3 = 3'(7 - op);
            Run = 1'b1; DIN = {o3, x3, y3, 7'h55};
            cyc(); Run = 1'b0;
            repeat (4) cyc();
        end

        @(posedge Clock);
        finished = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
